// File: rtl/ro_puf_challenge_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ro_puf_challenge_sequencer
//
// Purpose:
//   Drives the RO-PUF counter group through one challenge pair per response bit.
//   For each pair it holds the counter group in reset with the pair selected, then
//   releases reset for a fixed evaluation window and collects the 1-bit verdict.
//   The bits are gathered into a RESP_BITS-wide response word.
//
//   Outputs are registered decodes of the current state. They therefore trail
//   the state register by one cycle. Because of this, done rises
//   1 + RESP_BITS*(RST_CYCLES+EVAL_CYCLES+1) cycles after the accepting edge.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset, clears all state
//   start        in   one-cycle request, accepted only when idle and not busy
//   challenge    in   8-bit seed: [3:0] base for cha0, [7:4] base for cha1
//   cg_response  in   counter-group verdict, captured in SAMPLE
//   cg_reset     out  counter-group reset (low only while evaluating)
//   cg_cha0      out  4-bit ring-oscillator select A
//   cg_cha1      out  4-bit ring-oscillator select B
//   busy         out  high while a run is in progress
//   done         out  one-cycle pulse when the response word is complete
//   response     out  collected bits, bit k = verdict of pair k
// -----------------------------------------------------------------------------
module ro_puf_challenge_sequencer #(
    parameter int RESP_BITS   = 8,
    parameter int RST_CYCLES  = 4,
    parameter int EVAL_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           challenge,
    input  logic                 cg_response,
    output logic                 cg_reset,
    output logic [3:0]           cg_cha0,
    output logic [3:0]           cg_cha1,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response
);

    localparam int MAX_CYCLES = (RST_CYCLES > EVAL_CYCLES) ? RST_CYCLES : EVAL_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam int KW         = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TW-1:0] RST_LOAD  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] EVAL_LOAD = TW'(EVAL_CYCLES - 1);
    localparam logic [KW-1:0] LAST_K    = KW'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_CG,
        S_EVAL,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t         state, next_state;
    logic [TW-1:0]  timer;
    logic [KW-1:0]  k;
    logic [7:0]     seed;
    logic           accept;
    logic [3:0]     pair_a, pair_b, pair_b_fixed;

    // The busy register is still high in the cycle after DONE. Gating on it
    // keeps a start that arrives during the done pulse from being accepted.
    assign accept = (state == S_IDLE) && start && !busy;

    // Pair k selects oscillators (seed_lo+k, seed_hi+k) mod 16. Racing an
    // oscillator against itself carries no information. When both selects
    // coincide, the MSB of the second select is flipped.
    assign pair_a       = seed[3:0] + 4'(k);
    assign pair_b       = seed[7:4] + 4'(k);
    assign pair_b_fixed = (pair_a == pair_b) ? (pair_b ^ 4'b1000) : pair_b;

    // NOTE: state and datapath registers use non-blocking assignments so that
    // every register samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default first, so no path through the case
    // leaves it unassigned. Otherwise a latch would be inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept)        next_state = S_RST_CG;
            S_RST_CG: if (timer == '0)   next_state = S_EVAL;
            S_EVAL:   if (timer == '0)   next_state = S_SAMPLE;
            S_SAMPLE: next_state = (k == LAST_K) ? S_DONE : S_RST_CG;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cg_reset <= 1'b1;
            cg_cha0  <= '0;
            cg_cha1  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
            k        <= '0;
            timer    <= '0;
            seed     <= '0;
        end else begin
            cg_reset <= (state != S_EVAL);
            busy     <= (state != S_IDLE);
            done     <= (state == S_DONE);

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        seed     <= challenge;
                        response <= '0;
                        k        <= '0;
                        timer    <= RST_LOAD;
                    end
                end
                S_RST_CG: begin
                    // Selects are loaded only here. They then stay frozen
                    // through EVAL and SAMPLE.
                    cg_cha0 <= pair_a;
                    cg_cha1 <= pair_b_fixed;
                    timer   <= (timer == '0) ? EVAL_LOAD : timer - TW'(1);
                end
                S_EVAL: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                S_SAMPLE: begin
                    response[k] <= cg_response;
                    timer       <= RST_LOAD;
                    if (k != LAST_K) begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
